// File: rtl/enc_8to3_sync.sv
// -----------------------------------------------------------------------------
// enc_8to3_sync
//
// Registered 8-to-3 one-hot encoder with an input stability filter and a
// valid/ready output handshake. This is the inverse of the 3-to-8 one-hot
// decoder.
//
// The input must hold the same non-zero pattern for STABLE_CNT consecutive
// sampling edges before a decision is made. At that point:
//   - a one-hot pattern produces a 3-bit code, presented with out_valid until
//     the consumer accepts it;
//   - a pattern with two or more bits set produces a one-cycle err pulse and
//     bumps a saturating error counter.
// After either outcome the input must return to zero before another press is
// recognised, so a held key yields exactly one code or one error.
//
// Parameters:
//   STABLE_CNT : identical consecutive samples required (legal range 2..255)
//   CNT_W      : width of the stability counter and of err_cnt
//
// Ports:
//   sys_clk    in   1      system clock, rising edge
//   sys_rst_n  in   1      asynchronous active-low reset
//   in         in   8      one-hot request lines, bit i -> code i
//   out_ready  in   1      consumer accepts when high while out_valid is high
//   out        out  3      encoded index, meaningful while out_valid=1
//   out_valid  out  1      code available, held until accepted
//   err        out  1      one-cycle pulse on a stable non-one-hot pattern
//   err_cnt    out  CNT_W  number of err pulses, saturating at all-ones
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module enc_8to3_sync #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       in,
  input  logic             out_ready,
  output logic [2:0]       out,
  output logic             out_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILTER  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Counter value seen on the edge that makes the decision.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // ---------------------------------------------------------------------------
  // Snapshot decode: index of the set bit and one-hot qualification.
  // Code bit gi is the OR of every snapshot line whose index has bit gi set;
  // this is only meaningful when the snapshot is one-hot.
  // ---------------------------------------------------------------------------
  logic [2:0][7:0] code_sel;
  logic [2:0]      snap_code;
  logic [7:0]      snap_m1;
  logic            snap_onehot;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_code_bit
      for (genvar gj = 0; gj < 8; gj++) begin : g_line
        localparam logic LINE_HAS_BIT = ((gj >> gi) & 1) != 0;
        assign code_sel[gi][gj] = snap_q[gj] & LINE_HAS_BIT;
      end
      assign snap_code[gi] = |code_sel[gi];
    end
  endgenerate

  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign snap_m1     = snap_q - 8'd1;
  assign snap_onehot = (snap_q != 8'd0) && ((snap_q & snap_m1) == 8'd0);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;          // err is a pulse: low unless set below
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in != 8'd0) begin
          snap_d  = in;
          cnt_d   = CNT_ONE;
          state_d = S_FILTER;
        end
      end

      S_FILTER: begin
        if (in == 8'd0) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (in != snap_q) begin
          // Pattern moved: restart filtering on the new value.
          snap_d = in;
          cnt_d  = CNT_ONE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          // Decision edge: the snapshot has been stable long enough.
          cnt_d = '0;
          if (snap_onehot) begin
            out_d       = snap_code;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
            state_d = S_RELEASE;
          end
        end
      end

      S_HOLD: begin
        // Entry into HOLD coincides with out_valid rising, so out_ready is only
        // honoured from the following edge onward. out keeps its value after
        // acceptance.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (in == 8'd0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_enc_8to3_sync.sv
// Directed bench for enc_8to3_sync (STABLE_CNT=4, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_enc_8to3_sync;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] in;
  logic       out_ready;
  logic [2:0] out;
  logic       out_valid;
  logic       err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  enc_8to3_sync #(
    .STABLE_CNT(4),
    .CNT_W     (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in       (in),
    .out_ready(out_ready),
    .out      (out),
    .out_valid(out_valid),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    logic seen;
    logic [7:0] pat;

    sys_rst_n = 1'b0;
    in        = 8'h00;
    out_ready = 1'b0;
    tick(2);
    chk("rst_out",       {29'd0, out},  32'd0);
    chk("rst_valid",     {31'd0, out_valid}, 32'd0);
    chk("rst_err",       {31'd0, err},  32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    sys_rst_n = 1'b1;

    // ---- 8'h04 held, ready high: code after 4 edges, accepted next edge
    in = 8'h04; out_ready = 1'b1;
    tick(3);
    chk("t1_valid_e3", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t1_valid_e4", {31'd0, out_valid}, 32'd1);
    chk("t1_out",      {29'd0, out}, 32'd2);
    tick(1);
    chk("t1_accept",   {31'd0, out_valid}, 32'd0);
    chk("t1_out_kept", {29'd0, out}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | out_valid;
    end
    chk("t1_no_repeat", {31'd0, seen}, 32'd0);
    in = 8'h00; tick(1);
    in = 8'h04; tick(4);
    chk("t1_second_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_second_out",   {29'd0, out}, 32'd2);
    tick(1);
    in = 8'h00; tick(1);

    // ---- 8'h10 for two edges, then 8'h20: filter restarts
    in = 8'h10; tick(2);
    chk("t2_no_valid_10", {31'd0, out_valid}, 32'd0);
    in = 8'h20; tick(3);
    chk("t2_valid_e3", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t2_valid_e4", {31'd0, out_valid}, 32'd1);
    chk("t2_out",      {29'd0, out}, 32'd5);
    tick(1);
    in = 8'h00; tick(1);

    // ---- glitch of 3 samples: nothing happens
    in = 8'h08; tick(3);
    in = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen = seen | out_valid | err;
    end
    chk("glitch_quiet", {31'd0, seen}, 32'd0);

    // ---- non-one-hot pattern: err pulse, counter, saturation
    in = 8'h81; tick(4);
    chk("t3_err_pulse", {31'd0, err}, 32'd1);
    chk("t3_err_cnt1",  {24'd0, err_cnt}, 32'd1);
    chk("t3_no_valid",  {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t3_err_low",   {31'd0, err}, 32'd0);
    in = 8'h00; tick(1);
    for (int i = 0; i < 299; i++) begin
      in = 8'h81; tick(4);
      if (i == 253) chk("t3_err_cnt_255", {24'd0, err_cnt}, 32'hFF);
      if (i == 298) chk("t3_err_last_pulse", {31'd0, err}, 32'd1);
      in = 8'h00; tick(1);
    end
    chk("t3_err_cnt_sat", {24'd0, err_cnt}, 32'hFF);

    // ---- 8'h40 held, ready low for 10 cycles, input changes ignored
    out_ready = 1'b0;
    in = 8'h40; tick(4);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out",   {29'd0, out}, 32'd6);
    in = 8'h02;
    seen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen & out_valid & (out == 3'd6);
    end
    chk("t4_hold_stable", {31'd0, seen}, 32'd1);
    out_ready = 1'b1; tick(1);
    chk("t4_accept", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen = seen | out_valid;
    end
    chk("t4_release_waits", {31'd0, seen}, 32'd0);
    in = 8'h00; tick(1);

    // ---- asynchronous reset while in HOLD
    out_ready = 1'b0;
    in = 8'h40; tick(4);
    chk("t5_valid_before", {31'd0, out_valid}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",   {31'd0, out_valid}, 32'd0);
    chk("t5_rst_out",     {29'd0, out}, 32'd0);
    chk("t5_rst_err",     {31'd0, err}, 32'd0);
    chk("t5_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick(1);
    sys_rst_n = 1'b1;
    tick(3);
    chk("t5_refilter_e3", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t5_refilter_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_refilter_out",   {29'd0, out}, 32'd6);
    out_ready = 1'b1; tick(1);
    in = 8'h00; tick(1);

    // ---- sweep of all one-hot codes
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat = 8'h01 << i;
      in = pat; tick(4);
      seen = seen | err;
      chk($sformatf("sweep_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("sweep_out_%0d", i),   {29'd0, out}, 32'(i));
      tick(1);
      seen = seen | err;
      in = 8'h00; tick(1);
    end
    chk("sweep_no_err",  {31'd0, seen}, 32'd0);
    chk("sweep_err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_8to3_sync.md
Name: enc_8to3_sync

Overview:
- Registered 8-to-3 one-hot encoder with an input stability filter and a valid/ready output handshake. It performs the inverse function of the team's 3-to-8 one-hot decoder.
- Sits between an 8-line one-hot source (switch/key bank or decoder output) and a consumer that needs a 3-bit code.
- Input must hold a one-hot value for STABLE_CNT consecutive clocks before a code is produced.
- Non-one-hot stable patterns raise an error pulse and increment a saturating error counter.

Parameters:
- STABLE_CNT, 4, consecutive identical samples required before a decision; legal range 2..255.
- CNT_W, 8, width of the stability counter and of err_cnt.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in  input  8  one-hot request lines, synchronous to sys_clk; bit i maps to code i.
- out_ready  input  1  consumer accepts the code when high with out_valid high.
- out  output  3  encoded index of the set bit; valid only while out_valid=1.
- out_valid  output  1  code available; held until accepted.
- err  output  1  one-cycle pulse when a stable pattern is not one-hot.
- err_cnt  output  CNT_W  count of err pulses, saturating at all-ones.

Behaviour:
- Reset (sys_rst_n=0, asynchronous): out=3'd0, out_valid=0, err=0, err_cnt=0, internal snapshot=0, counter=0, state=IDLE. Deassertion takes effect at the next rising edge. Reset mid-handshake discards the pending code.
- All outputs are registered; no combinational path from in or out_ready to any output.
- State IDLE:
  - If in==0, stay in IDLE.
  - If in!=0, snap<=in, cnt<=1, go to FILTER.
- State FILTER:
  - If in==0, go to IDLE and cnt<=0.
  - If in!=0 and in!=snap, snap<=in and cnt<=1 (restart filtering).
  - If in==snap and cnt<STABLE_CNT-1, cnt<=cnt+1.
  - If in==snap and cnt==STABLE_CNT-1 (decision edge):
    - snap one-hot: out<=index of the set bit, out_valid<=1, go to HOLD.
    - snap not one-hot (two or more bits set): err<=1 for exactly one cycle, err_cnt<=err_cnt+1 unless all-ones, go to RELEASE.
- Latency: if in becomes stable before edge k (captured in IDLE), out_valid is high after edge k+STABLE_CNT-1. With STABLE_CNT=4, that is 4 sampling edges including the capture edge.
- State HOLD:
  - out and out_valid are stable; in is ignored.
  - On an edge with out_ready=1: out_valid<=0, go to RELEASE. out keeps its last value.
  - out_ready high on the same edge that out_valid first rises does not count; acceptance requires out_valid already high.
- State RELEASE:
  - Wait for in==0 sampled on an edge, then go to IDLE.
  - A held key produces exactly one code or one error per press.
- err is 0 in every cycle except the single cycle after a decision edge that detected a non-one-hot pattern.
- err_cnt at all-ones stays all-ones; err still pulses.
- Encoding: in=8'h01 gives out=0; 8'h80 gives out=7.
- Glitch shorter than STABLE_CNT samples: no output and no error.

Test Plan:
- Reset then in=8'h04 held, out_ready=1, STABLE_CNT=4 -> out_valid rises 4 edges after capture with out=3'd2. Accepted next edge, out_valid=0. No second code while held. in=0 then 8'h04 again -> new code.
- in=8'h10 for 2 cycles, then 8'h20 held -> filter restarts on change. out=3'd5 appears 4 edges after 8'h20 is captured, never out=4.
- in=8'h81 held -> err pulses exactly one cycle, err_cnt=1, out_valid stays 0. Release to 0 and repeat 300 times -> err_cnt saturates at 8'hFF.
- in=8'h40 held, out_ready=0 for 10 cycles -> out_valid=1 and out=3'd6 held throughout, in changed to 8'h02 meanwhile has no effect. out_ready=1 -> accepted, then RELEASE waits for in==0.
- sys_rst_n pulsed low asynchronously while in HOLD -> out_valid, out, err, err_cnt go to 0 immediately. After release with in still 8'h40, a fresh filter sequence produces out=3'd6 after STABLE_CNT edges.
- Sweep in=8'h01..8'h80 one-hot, each held then released -> out equals 0..7 in order, err never asserted.
